// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam int unsigned REG_W_DEF = 5;

    // Register $zero never carries a real dependency.
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared by reset.
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage MIPS pipeline: load-use stalls, branch
// squashes and frozen data-memory waits with timeout, plus a stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W       = REG_W_DEF,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IdExMemRead,
    input  logic [REG_W-1:0] IdExRt,
    input  logic [REG_W-1:0] IfIdRs,
    input  logic [REG_W-1:0] IfIdRt,
    input  logic             ExMemMemRead,
    input  logic             ExMemMemWrite,
    input  logic             memAck,
    input  logic             branchTaken,
    output logic             memReq,
    output logic             PcWrite,
    output logic             IfIdWrite,
    output logic             IfIdFlush,
    output logic             IdExWrite,
    output logic             IdExBubble,
    output logic             ExMemWrite,
    output logic             MemWbBubble,
    output logic             memError,
    output logic [CNT_W-1:0] stallCycles
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                mem_access;
    logic                load_use;
    logic                hz_eval;

    always_comb begin
        mem_access = ExMemMemRead | ExMemMemWrite;
        load_use   = IdExMemRead && (IdExRt != REG_W'(REG_ZERO)) &&
                     ((IdExRt == IfIdRs) || (IdExRt == IfIdRt));
    end

    // Control outputs: combinational from state and current inputs.
    always_comb begin
        memReq      = mem_access;
        PcWrite     = 1'b1;
        IfIdWrite   = 1'b1;
        IfIdFlush   = 1'b0;
        IdExWrite   = 1'b1;
        IdExBubble  = 1'b0;
        ExMemWrite  = 1'b1;
        MemWbBubble = 1'b0;
        hz_eval     = 1'b0;

        case (state)
            RUN: begin
                if (mem_access && !memAck) begin
                    memReq      = 1'b1;
                    PcWrite     = 1'b0;
                    IfIdWrite   = 1'b0;
                    IdExWrite   = 1'b0;
                    ExMemWrite  = 1'b0;
                    MemWbBubble = 1'b1;
                end else begin
                    hz_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                memReq = 1'b1;
                if (memAck) begin
                    hz_eval = 1'b1;
                end else begin
                    PcWrite     = 1'b0;
                    IfIdWrite   = 1'b0;
                    IdExWrite   = 1'b0;
                    ExMemWrite  = 1'b0;
                    MemWbBubble = 1'b1;
                end
            end
            HALT: begin
                memReq      = 1'b0;
                PcWrite     = 1'b0;
                IfIdWrite   = 1'b0;
                IdExWrite   = 1'b0;
                ExMemWrite  = 1'b0;
                MemWbBubble = 1'b1;
            end
            default: begin
                hz_eval = 1'b1;
            end
        endcase

        // A taken branch squashes the ID instruction, so its load-use is moot.
        if (hz_eval) begin
            if (branchTaken) begin
                IfIdFlush  = 1'b1;
                IdExBubble = 1'b1;
            end else if (load_use) begin
                PcWrite    = 1'b0;
                IfIdWrite  = 1'b0;
                IdExBubble = 1'b1;
            end
        end
    end

    // Sequencer state, memory wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            memError <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_access && !memAck) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (memAck) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        memError <= 1'b1;
                        state    <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    logic pc_stalled;
    assign pc_stalled = ~PcWrite;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_stalled),
        .count (stallCycles)
    );

endmodule
